demux_1ton_stream: RTL and testbench

//  Registered, parametrised 1-to-N stream demultiplexer. Routes each accepted input word to the

---
 rtl/demux_1ton_stream.sv | 103 ++++++++++
 tb/tb_demux_1ton_stream.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_1ton_stream.sv
// demux_1ton_stream
//   Registered 1-to-N stream demultiplexer with a single one-word holding
//   stage. Each accepted input word is stored in data_q and flagged pending
//   on the channel named by in_sel. Every output lane carries data_q, and
//   out_valid marks which channels still owe a transfer.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   producer handshake
//   in_data [DW]        input word
//   in_sel  [SW]        destination channel; values >= N are dropped
//   in_bcast            broadcast request (only with DEMUX_BCAST_EN)
//   out_valid[N]        per-channel valid (the pending mask)
//   out_ready[N]        per-channel ready
//   out_data[N*DW]      lane k = out_data[k*DW +: DW], all lanes = data_q
//   drop_cnt[8]         saturating count of out-of-range drops
//
// Build option
//   DEMUX_BCAST_EN : adds in_bcast; a broadcast accept marks all N channels
//                    pending and each channel drains independently.
module demux_1ton_stream #(
  parameter  int DW = 8,
  parameter  int N  = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  input  logic [SW-1:0]   in_sel,
`ifdef DEMUX_BCAST_EN
  input  logic            in_bcast,
`endif
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [N*DW-1:0] out_data,
  output logic [7:0]      drop_cnt
);

  localparam logic [SW:0]  SEL_LIM = (SW+1)'(N);
  localparam logic [N-1:0] ONE     = {{(N-1){1'b0}}, 1'b1};

  logic [DW-1:0] data_q, data_d;
  logic [N-1:0]  pend_q, pend_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;

  logic [N-1:0]  busy;      // pending channels not transferring this cycle
  logic          accept;
  logic          in_range;
  logic          bcast_req;

`ifdef DEMUX_BCAST_EN
  assign bcast_req = in_bcast;
`else
  assign bcast_req = 1'b0;
`endif

  always_comb begin
    busy       = pend_q & ~out_ready;
    in_ready   = (busy == '0);
    accept     = in_valid & in_ready;
    in_range   = ({1'b0, in_sel} < SEL_LIM);
    // Clears land first; an accept then overwrites the mask. Since an accept
    // needs busy==0, the post-clear mask is already zero at that point.
    pend_d     = busy;
    data_d     = data_q;
    drop_cnt_d = drop_cnt_q;
    if (accept) begin
      if (bcast_req) begin
        pend_d = '1;
        data_d = in_data;
      end else if (in_range) begin
        pend_d = ONE << in_sel;
        data_d = in_data;
      end else begin
        // Out-of-range word is consumed; data_q keeps its old value.
        pend_d = '0;
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q     <= '0;
      pend_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      data_q     <= data_d;
      pend_q     <= pend_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_valid = pend_q;
  assign drop_cnt  = drop_cnt_q;

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign out_data[k*DW +: DW] = data_q;
  end

endmodule

// File: tb/tb_demux_1ton_stream.sv
// Bench for demux_1ton_stream: N=8 instance scoreboarded on every output
// transfer, plus an N=5 instance for out-of-range drops and saturation.
module tb_demux_1ton_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // N=8 instance
  logic        in_valid, in_ready, in_bcast;
  logic [7:0]  in_data;
  logic [2:0]  in_sel;
  logic [7:0]  out_valid, out_ready, drop_cnt;
  logic [63:0] out_data;
  // N=5 instance
  logic        in_valid5, in_ready5;
  logic [7:0]  in_data5, drop_cnt5;
  logic [2:0]  in_sel5;
  logic [4:0]  out_valid5, out_ready5;
  logic [39:0] out_data5;

  demux_1ton_stream #(.DW(8), .N(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel),
`ifdef DEMUX_BCAST_EN
    .in_bcast(in_bcast),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt));

  demux_1ton_stream #(.DW(8), .N(5)) dut5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_data(in_data5), .in_sel(in_sel5),
`ifdef DEMUX_BCAST_EN
    .in_bcast(1'b0),
`endif
    .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
    .drop_cnt(drop_cnt5));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: expected (channel, data) pushed on accept, popped on transfer.
  typedef struct { logic [2:0] ch; logic [7:0] d; } sb_t;
  sb_t  q[$];
  bit   sb_en = 1'b1;
  logic [7:0] hold_mask = '0;
  logic [7:0] hold_data = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q.delete();
      hold_mask = '0;
    end else begin
      // A channel that was pending and not ready must still be pending with
      // the same data one cycle later.
      if (hold_mask != 0) begin
        chk("hold_valid", 64'(out_valid & hold_mask), 64'(hold_mask));
        chk("hold_data", 64'(out_data[7:0]), 64'(hold_data));
      end
      hold_mask = out_valid & ~out_ready;
      hold_data = out_data[7:0];
      if (sb_en) begin
        for (int k = 0; k < 8; k++) begin
          if (out_valid[k] && out_ready[k]) begin
            sb_t e;
            if (q.size() == 0) begin
              n_cmp++; n_err++;
              $display("FAIL sb_unexpected: transfer on ch %0d with empty queue", k);
            end else begin
              e = q.pop_front();
              chk("sb_ch", 64'(k), 64'(e.ch));
              chk("sb_data", 64'(out_data[k*8 +: 8]), 64'(e.d));
            end
          end
        end
        if (in_valid && in_ready) q.push_back('{in_sel, in_data});
      end
    end
  end

  typedef struct { logic [7:0] d; logic [2:0] sel; logic [7:0] exp_v; } vec_t;
  vec_t vec [8];
  bit   acc;

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: bench did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    in_valid = 0; in_data = 0; in_sel = 0; in_bcast = 0; out_ready = 0;
    in_valid5 = 0; in_data5 = 0; in_sel5 = 0; out_ready5 = '1;
    for (int i = 0; i < 8; i++) begin
      vec[i].d     = 8'(i + 1);
      vec[i].sel   = 3'(i);
      vec[i].exp_v = 8'h01 << i;
    end

    // Power-on reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_ready", 64'(in_ready), 64'h1);
    chk("rst_drop", 64'(drop_cnt), 64'h0);
    chk("rst_data", out_data, 64'h0);
    rst_n = 1;

    // Reset while holding 0xA5 for ch3
    @(posedge clk); #1;
    in_valid = 1; in_data = 8'hA5; in_sel = 3; out_ready = 0;
    @(posedge clk); #1;
    in_valid = 0;
    chk("hold_a5_valid", 64'(out_valid), 64'h08);
    chk("hold_a5_ready", 64'(in_ready), 64'h0);
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'h0);
    chk("async_rst_ready", 64'(in_ready), 64'h1);
    chk("async_rst_drop", 64'(drop_cnt), 64'h0);
    chk("async_rst_data", out_data, 64'h0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("post_rst_valid", 64'(out_valid), 64'h0);
    chk("post_rst_ready", 64'(in_ready), 64'h1);
    chk("post_rst_data", out_data, 64'h0);

    // Sweep: one word per clock, all channels ready
    @(posedge clk); #1;
    out_ready = '1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_data = vec[i].d; in_sel = vec[i].sel;
      @(negedge clk);
      chk("sweep_in_ready", 64'(in_ready), 64'h1);
      @(posedge clk); #1;
      chk("sweep_valid", 64'(out_valid), 64'(vec[i].exp_v));
      chk("sweep_lane", 64'(out_data[i*8 +: 8]), 64'(vec[i].d));
    end
    in_valid = 0;
    @(posedge clk); #1;
    chk("sweep_drain", 64'(out_valid), 64'h0);

    // Backpressure on ch5, then same-edge accept of the next word
    out_ready = 0;
    in_valid = 1; in_data = 8'h3C; in_sel = 5;
    @(posedge clk); #1;
    chk("bp_valid", 64'(out_valid), 64'h20);
    in_data = 8'h77; in_sel = 2;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'h0);
      chk("bp_held", 64'(out_valid), 64'h20);
      chk("bp_lane5", 64'(out_data[40 +: 8]), 64'h3C);
      @(posedge clk); #1;
    end
    out_ready = 8'h20;
    @(negedge clk);
    chk("bp_release_ready", 64'(in_ready), 64'h1);
    @(posedge clk); #1;
    chk("bp_next_valid", 64'(out_valid), 64'h04);
    chk("bp_next_lane2", 64'(out_data[16 +: 8]), 64'h77);
    in_valid = 0; out_ready = '1;
    @(posedge clk); #1;
    chk("bp_drain", 64'(out_valid), 64'h0);

    // Out-of-range drops on N=5
    in_valid5 = 1; in_data5 = 8'h11; in_sel5 = 6;
    @(posedge clk); #1;
    in_sel5 = 7;
    @(posedge clk); #1;
    in_valid5 = 0;
    chk("oor_valid", 64'(out_valid5), 64'h0);
    chk("oor_drop2", 64'(drop_cnt5), 64'h2);
    chk("oor_data_kept", 64'(out_data5[7:0]), 64'h0);
    in_valid5 = 1; in_data5 = 8'h5A; in_sel5 = 4;
    @(posedge clk); #1;
    in_valid5 = 0;
    chk("n5_valid", 64'(out_valid5), 64'h10);
    chk("n5_lane4", 64'(out_data5[32 +: 8]), 64'h5A);
    @(posedge clk); #1;
    chk("n5_drain", 64'(out_valid5), 64'h0);
    in_valid5 = 1; in_sel5 = 6;
    repeat (252) @(posedge clk);
    #1;
    chk("oor_drop254", 64'(drop_cnt5), 64'd254);
    repeat (6) @(posedge clk);
    #1;
    in_valid5 = 0;
    chk("oor_sat255", 64'(drop_cnt5), 64'd255);
    chk("oor_data_still", 64'(out_data5[7:0]), 64'h5A);

`ifdef DEMUX_BCAST_EN
    // Broadcast: channels drain independently
    sb_en = 0;
    out_ready = 8'h0F;
    in_valid = 1; in_bcast = 1; in_data = 8'hC3;
    @(posedge clk); #1;
    in_valid = 0; in_bcast = 0;
    chk("bc_all", 64'(out_valid), 64'hFF);
    chk("bc_lane7", 64'(out_data[56 +: 8]), 64'hC3);
    @(negedge clk);
    chk("bc_ready0", 64'(in_ready), 64'h0);
    @(posedge clk); #1;
    chk("bc_upper", 64'(out_valid), 64'hF0);
    @(negedge clk);
    chk("bc_ready1", 64'(in_ready), 64'h0);
    @(posedge clk); #1;
    out_ready = 8'hF0;
    @(negedge clk);
    chk("bc_ready2", 64'(in_ready), 64'h1);
    @(posedge clk); #1;
    chk("bc_done", 64'(out_valid), 64'h0);
    out_ready = '1;
    @(negedge clk);
    sb_en = 1;
`endif

    // Random backpressure; producer holds its word until accepted
    acc = 0;
    repeat (300) begin
      @(posedge clk); #1;
      out_ready = 8'($urandom);
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
        in_sel   = 3'($urandom_range(0, 7));
      end
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    @(posedge clk); #1;
    in_valid = 0; out_ready = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rand_drain_valid", 64'(out_valid), 64'h0);
    chk("rand_queue_empty", 64'(q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
